// File: rtl/audio_pkg.sv
// Shared audio types and constants for the sample feeder and its FIFO.
package audio_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int SCLK_PER_FRAME = 32;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_t;

    // Saturating increment used by the underrun counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo-sample FIFO with an explicit occupancy counter.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = $bits(stereo_t)
) (
    input  logic                     audio_sclk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_fill,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [FW-1:0]    r_fill;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_fill == FW'(DEPTH));
    assign o_empty = (r_fill == '0);
    assign o_fill  = r_fill;
    assign o_data  = r_mem[r_rd_ptr];

    // Guard internally as well so a caller can never over- or under-run the pointers.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge audio_sclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge audio_sclk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_feeder.sv
// Decouples a bursty stereo sample producer from the fixed-rate serializer:
// one FIFO pop per detected audio_lrclk rising edge, with mute and underrun handling.
module audio_sample_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = SAMPLE_W
) (
    input  logic                   audio_sclk,
    input  logic                   rst,
    input  logic                   audio_lrclk,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_left,
    input  logic [W-1:0]           in_right,
    input  logic                   mute,
    output logic [W-1:0]           audio_left,
    output logic [W-1:0]           audio_right,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   underrun,
    output logic [7:0]             underrun_cnt
);

    logic                   r_lrclk_q;
    logic [W-1:0]           r_audio_left;
    logic [W-1:0]           r_audio_right;
    logic                   r_underrun;
    logic [7:0]             r_underrun_cnt;

    logic                   w_frame_tick;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_fill;
    stereo_t                w_wr_pair;
    stereo_t                w_head;

    assign w_frame_tick = audio_lrclk & ~r_lrclk_q;
    assign in_ready     = ~w_full;
    assign w_push       = in_valid & in_ready;
    // A push landing on an empty FIFO during a tick is stored, not bypassed.
    assign w_pop        = w_frame_tick & ~w_empty;

    assign w_wr_pair.left  = in_left;
    assign w_wr_pair.right = in_right;

    audio_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(stereo_t))
    ) u_fifo (
        .audio_sclk (audio_sclk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_data     (w_wr_pair),
        .o_data     (w_head),
        .o_fill     (w_fill),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge audio_sclk or negedge rst) begin
        if (!rst) begin
            r_lrclk_q      <= 1'b0;
            r_audio_left   <= '0;
            r_audio_right  <= '0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_lrclk_q  <= audio_lrclk;
            r_underrun <= 1'b0;
            if (w_frame_tick) begin
                if (w_empty) begin
                    r_audio_left   <= '0;
                    r_audio_right  <= '0;
                    r_underrun     <= 1'b1;
                    r_underrun_cnt <= sat_inc8(r_underrun_cnt);
                end else if (mute) begin
                    // Muted frames still consume a sample to keep the stream in step.
                    r_audio_left  <= '0;
                    r_audio_right <= '0;
                end else begin
                    r_audio_left  <= w_head.left;
                    r_audio_right <= w_head.right;
                end
            end
        end
    end

    assign audio_left   = r_audio_left;
    assign audio_right  = r_audio_right;
    assign fill         = w_fill;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder: directed scenarios plus a randomized
// run against a queue-based reference model of the feeder's behaviour.
module tb_audio_sample_feeder;
    import audio_pkg::*;

    localparam int DEPTH = 8;

    logic        audio_sclk = 1'b0;
    logic        rst = 1'b0;
    logic        audio_lrclk = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        mute = 1'b0;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic [3:0]  fill;
    logic        underrun;
    logic [7:0]  underrun_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic        m_prev_lr = 1'b0;
    logic [15:0] m_l = '0;
    logic [15:0] m_r = '0;
    logic        m_under = 1'b0;
    int          m_cnt = 0;

    always #5 audio_sclk = ~audio_sclk;

    audio_sample_feeder #(.DEPTH(DEPTH), .W(16)) dut (
        .audio_sclk   (audio_sclk),
        .rst          (rst),
        .audio_lrclk  (audio_lrclk),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_left      (in_left),
        .in_right     (in_right),
        .mute         (mute),
        .audio_left   (audio_left),
        .audio_right  (audio_right),
        .fill         (fill),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    // Drive one SCLK cycle and advance the model; returns 1 ns after the rising edge.
    task automatic drive_cycle(input logic lr, input logic v, input logic [31:0] d, input logic mu);
        logic [31:0] head;
        bit          accept;
        audio_lrclk = lr;
        in_valid    = v;
        in_left     = d[31:16];
        in_right    = d[15:0];
        mute        = mu;
        if (!rst) begin
            m_q.delete();
            m_prev_lr = 1'b0;
            m_l = '0;
            m_r = '0;
            m_under = 1'b0;
            m_cnt = 0;
        end else begin
            accept  = v && (m_q.size() < DEPTH);
            m_under = 1'b0;
            if (lr && !m_prev_lr) begin
                if (m_q.size() == 0) begin
                    m_l = '0;
                    m_r = '0;
                    m_under = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    head = m_q.pop_front();
                    m_l = mu ? 16'h0 : head[31:16];
                    m_r = mu ? 16'h0 : head[15:0];
                end
            end
            m_prev_lr = lr;
            if (accept) m_q.push_back(d);
        end
        @(posedge audio_sclk);
        #1;
    endtask

    // One 32-SCLK frame (lrclk high then low); optional push on the tick cycle.
    task automatic do_frame(input logic mu, input logic pv, input logic [31:0] pd, output int pulses);
        pulses = 0;
        for (int i = 0; i < SCLK_PER_FRAME; i++) begin
            drive_cycle(i < SCLK_PER_FRAME / 2, (i == 0) ? pv : 1'b0, pd, mu);
            if (underrun === 1'b1) pulses++;
        end
        $display("frame: out=%h/%h fill=%0d underrun_pulses=%0d cnt=%0d",
                 audio_left, audio_right, fill, pulses, underrun_cnt);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i[0], 1'b1, $urandom(), 1'b0);
            n_total++;
            if ({audio_left, audio_right} !== 32'h0) begin
                n_bad++; $display("FAIL reset_out: got %h want 0", {audio_left, audio_right});
            end
            n_total++;
            if (fill !== 4'd0 || in_ready !== 1'b1 || underrun !== 1'b0 || underrun_cnt !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_state: fill=%0d in_ready=%b underrun=%b cnt=%0d want 0/1/0/0",
                         fill, in_ready, underrun, underrun_cnt);
            end
        end
        audio_lrclk = 1'b0;
        rst = 1'b1;
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        $display("reset released: fill=%0d in_ready=%b", fill, in_ready);
    endtask

    task automatic test_ordered();
        logic [31:0] s [3] = '{32'h1234_8000, 32'h7FFF_0001, 32'hFFFF_5555};
        int p;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, s[i], 1'b0);
            n_total++;
            if (fill !== 4'(i + 1)) begin
                n_bad++; $display("FAIL ordered_push_fill: got %0d want %0d", fill, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_frame(1'b0, 1'b0, 32'h0, p);
            n_total++;
            if ({audio_left, audio_right} !== s[i] || fill !== 4'(2 - i) || p != 0) begin
                n_bad++;
                $display("FAIL ordered_frame%0d: got %h fill=%0d pulses=%0d want %h fill=%0d pulses=0",
                         i, {audio_left, audio_right}, fill, p, s[i], 2 - i);
            end
        end
        do_frame(1'b0, 1'b0, 32'h0, p);
        n_total++;
        if ({audio_left, audio_right} !== 32'h0 || p != 1 || underrun_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL ordered_underrun: got %h pulses=%0d cnt=%0d want 0 pulses=1 cnt=1",
                     {audio_left, audio_right}, p, underrun_cnt);
        end
    endtask

    task automatic test_full_and_simultaneous();
        logic [31:0] s [9];
        int p;
        for (int i = 0; i < 9; i++) s[i] = {16'hA000 + 16'(i), 16'h5000 + 16'(i)};
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (in_ready !== (i < 8)) begin
                n_bad++; $display("FAIL full_in_ready%0d: got %b want %b", i, in_ready, i < 8);
            end
            drive_cycle(1'b0, 1'b1, s[i], 1'b0);
        end
        n_total++;
        if (fill !== 4'd8 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_level: fill=%0d in_ready=%b want 8/0", fill, in_ready);
        end
        do_frame(1'b0, 1'b0, 32'h0, p);
        n_total++;
        if (fill !== 4'd7 || in_ready !== 1'b1 || {audio_left, audio_right} !== s[0]) begin
            n_bad++;
            $display("FAIL full_after_frame: fill=%0d in_ready=%b out=%h want 7/1/%h",
                     fill, in_ready, {audio_left, audio_right}, s[0]);
        end
        for (int i = 0; i < 3; i++) do_frame(1'b0, 1'b0, 32'h0, p);
        // fill is 4 here; push on the tick cycle itself
        do_frame(1'b0, 1'b1, 32'hCAFE_BEEF, p);
        n_total++;
        if (fill !== 4'd4 || {audio_left, audio_right} !== s[4] || p != 0) begin
            n_bad++;
            $display("FAIL simul_nonempty: fill=%0d out=%h pulses=%0d want 4/%h/0",
                     fill, {audio_left, audio_right}, p, s[4]);
        end
        for (int i = 0; i < 4; i++) do_frame(1'b0, 1'b0, 32'h0, p);
        n_total++;
        if (fill !== 4'd0 || {audio_left, audio_right} !== 32'hCAFE_BEEF) begin
            n_bad++;
            $display("FAIL simul_drain: fill=%0d out=%h want 0/cafebeef", fill, {audio_left, audio_right});
        end
        do_frame(1'b0, 1'b1, 32'h0BAD_F00D, p);
        n_total++;
        if (fill !== 4'd1 || p != 1 || {audio_left, audio_right} !== 32'h0) begin
            n_bad++;
            $display("FAIL simul_empty: fill=%0d pulses=%0d out=%h want 1/1/0",
                     fill, p, {audio_left, audio_right});
        end
        do_frame(1'b0, 1'b0, 32'h0, p);
        n_total++;
        if (fill !== 4'd0 || {audio_left, audio_right} !== 32'h0BAD_F00D || p != 0) begin
            n_bad++;
            $display("FAIL simul_empty_next: fill=%0d out=%h pulses=%0d want 0/0badf00d/0",
                     fill, {audio_left, audio_right}, p);
        end
    endtask

    task automatic test_mute();
        int p;
        drive_cycle(1'b0, 1'b1, 32'h1111_2222, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h3333_4444, 1'b0);
        do_frame(1'b1, 1'b0, 32'h0, p);
        n_total++;
        if ({audio_left, audio_right} !== 32'h0 || fill !== 4'd1 || p != 0) begin
            n_bad++;
            $display("FAIL mute_frame: out=%h fill=%0d pulses=%0d want 0/1/0",
                     {audio_left, audio_right}, fill, p);
        end
        do_frame(1'b0, 1'b0, 32'h0, p);
        n_total++;
        if ({audio_left, audio_right} !== 32'h3333_4444 || fill !== 4'd0) begin
            n_bad++;
            $display("FAIL mute_next: out=%h fill=%0d want 33334444/0", {audio_left, audio_right}, fill);
        end
    endtask

    task automatic test_random();
        logic lr, v, mu;
        int   phase;
        mu = 1'b0;
        for (int c = 0; c < 40 * SCLK_PER_FRAME; c++) begin
            phase = c % SCLK_PER_FRAME;
            lr    = (phase < SCLK_PER_FRAME / 2);
            if (phase == 0) mu = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 63) < ((c < 20 * SCLK_PER_FRAME) ? 5 : 1));
            drive_cycle(lr, v, $urandom(), mu);
            n_total++;
            if (audio_left !== m_l || audio_right !== m_r) begin
                n_bad++;
                $display("FAIL rand_out c=%0d: got %h/%h want %h/%h", c, audio_left, audio_right, m_l, m_r);
            end
            n_total++;
            if (fill !== 4'(m_q.size()) || in_ready !== (m_q.size() != DEPTH)) begin
                n_bad++;
                $display("FAIL rand_fill c=%0d: fill=%0d in_ready=%b want %0d/%b",
                         c, fill, in_ready, m_q.size(), m_q.size() != DEPTH);
            end
            n_total++;
            if (underrun !== m_under || underrun_cnt !== 8'(m_cnt)) begin
                n_bad++;
                $display("FAIL rand_underrun c=%0d: pulse=%b cnt=%0d want %b/%0d",
                         c, underrun, underrun_cnt, m_under, m_cnt);
            end
            if (phase == 0) $display("rand frame %0d: out=%h/%h fill=%0d", c / SCLK_PER_FRAME,
                                     audio_left, audio_right, fill);
        end
    endtask

    task automatic test_saturation();
        int p, total;
        for (int k = 0; k < DEPTH + 2 && m_q.size() != 0; k++) do_frame(1'b0, 1'b0, 32'h0, p);
        total = 0;
        for (int k = 0; k < 300; k++) begin
            do_frame(1'b0, 1'b0, 32'h0, p);
            total += p;
        end
        n_total++;
        if (underrun_cnt !== 8'd255 || total != 300) begin
            n_bad++;
            $display("FAIL saturation: cnt=%0d pulses=%0d want 255/300", underrun_cnt, total);
        end
        drive_cycle(1'b0, 1'b1, 32'h4242_2424, 1'b0);
        do_frame(1'b0, 1'b0, 32'h0, p);
        drive_cycle(1'b0, 1'b1, 32'h9999_8888, 1'b0);
        n_total++;
        if ({audio_left, audio_right} !== 32'h4242_2424 || underrun_cnt !== 8'd255 || fill !== 4'd1) begin
            n_bad++;
            $display("FAIL pre_reset: out=%h cnt=%0d fill=%0d want 42422424/255/1",
                     {audio_left, audio_right}, underrun_cnt, fill);
        end
        // Asynchronous reset: checked before any further clock edge.
        rst = 1'b0;
        #2;
        n_total++;
        if (underrun_cnt !== 8'd0 || {audio_left, audio_right} !== 32'h0 || fill !== 4'd0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: cnt=%0d out=%h fill=%0d in_ready=%b want 0/0/0/1",
                     underrun_cnt, {audio_left, audio_right}, fill, in_ready);
        end
        $display("mid-run reset: cnt=%0d fill=%0d", underrun_cnt, fill);
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
        do_frame(1'b0, 1'b0, 32'h0, p);
        n_total++;
        if (underrun_cnt !== 8'd1 || p != 1) begin
            n_bad++;
            $display("FAIL post_reset_count: cnt=%0d pulses=%0d want 1/1", underrun_cnt, p);
        end
    endtask

    initial begin
        test_reset();
        test_ordered();
        test_full_and_simultaneous();
        test_mute();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_sample_feeder.md
# audio_sample_feeder

Buffers stereo PCM samples from an upstream producer, such as a tone or note generator, and presents one stable 16-bit left/right pair per audio frame to `speaker_control`. It runs entirely in the `audio_sclk` domain and uses `audio_lrclk` only as a sampled frame marker. Its job is to decouple bursty sample production from the fixed 32-SCLK frame rate of the serializer. Underrun and mute handling are included.

## Interface
- `DEPTH`, 8: FIFO depth in stereo samples; power of two, ≥2.
- `W`, 16: sample width per channel; fixed at 16 for `speaker_control`.

- `audio_sclk` in 1: serial bit clock; all state is clocked on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `audio_lrclk` in 1: frame clock; 32 SCLK periods per frame; sampled, never used as a clock.
- `in_valid` in 1: producer offers `in_left`/`in_right`.
- `in_ready` out 1: FIFO can accept a sample this cycle.
- `in_left` in W: left sample, two's complement.
- `in_right` in W: right sample, two's complement.
- `mute` in 1: force zero output at the next frame update.
- `audio_left` out W: left sample to the serializer.
- `audio_right` out W: right sample to the serializer.
- `fill` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `underrun` out 1: one-cycle pulse when a frame update finds the FIFO empty.
- `underrun_cnt` out 8: saturating count of underruns.

## Operation
- **Frame marker**
  - `lrclk_q` registers `audio_lrclk` every cycle.
  - `frame_tick = audio_lrclk & ~lrclk_q`, i.e. the detected rising edge.
  - Updating on the rising edge keeps the outputs stable for ≥15 SCLK before the serializer latches at the `audio_lrclk` falling edge.
- **Push**: occurs when `in_valid & in_ready`; the pair is written at the write pointer and the write pointer increments mod DEPTH.
- **`in_ready`**: equals `fill != DEPTH`.
  - Full-cycle pushes are refused, since `in_ready` is 0.
  - No push bypass on the same-cycle pop.
- **Pop**: occurs on `frame_tick` with `fill != 0`.
  - Outputs load the head pair, or 0/0 if `mute` is 1 on that cycle.
  - The read pointer increments.
  - Mute still consumes the sample, so the frame rate is preserved.
- **Underrun**: occurs on `frame_tick` with `fill == 0`.
  - Outputs load 0/0.
  - `underrun` pulses high for 1 cycle.
  - `underrun_cnt` increments and saturates at 255.
- **Simultaneous push and pop**: both take effect and `fill` is unchanged. A push into an empty FIFO on a `frame_tick` cycle still raises an underrun; the pushed data is stored and popped at the next frame.
- **Arithmetic**
  - Pointers are `$clog2(DEPTH)` bits with natural wrap.
  - `fill` is a separate counter updated by +1 (push only), −1 (pop only), or 0.
- **Data path**: no arithmetic on samples; values pass through bit-exact.

## Timing
- **Reset values** (on `rst` low, asynchronously)
  - `audio_left`, `audio_right`: 0
  - `fill`: 0
  - `in_ready`: 1
  - `underrun`: 0
  - `underrun_cnt`: 0
  - pointers: 0
  - `lrclk_q`: 0
- **Reset mid-operation**: FIFO contents are discarded and outputs return to 0 immediately.
- **First `frame_tick` after reset**: requires an observed low→high transition of `audio_lrclk`. If `audio_lrclk` is already high at reset release, a tick fires on the first edge because `lrclk_q` resets to 0; this is accepted behaviour.
- **Latency**
  - Push to `fill` update: 1 cycle.
  - Sample reaches the outputs at the first `frame_tick` at which it is the head entry.
- **Outputs**: change only on the cycle following a `frame_tick`, i.e. at most once per 32 SCLK.
- **`in_ready`**: combinational from the registered `fill`; no combinational path from `in_valid`.

## Structure
- **Shared package `audio_pkg`**
  - `SAMPLE_W = 16`
  - `SCLK_PER_FRAME = 32`
  - typedef `stereo_t` as packed {left, right}
- **Sub-module `audio_sample_fifo`**
  - Synchronous FIFO with push, pop, data, fill, full, empty.
  - Width `2*W`, depth `DEPTH`.
- **Top level**: holds the frame-edge detector, output registers, mute select and underrun counter.

## Test plan
- **Reset**
  - Stimulus: hold `rst`=0 while `audio_lrclk` toggles.
  - Required: outputs 0/0, `fill`=0, `in_ready`=1, no `underrun` pulse.
- **Ordered playback**
  - Stimulus: push (0x1234,0x8000), (0x7FFF,0x0001), (0xFFFF,0x5555) before the first frame.
  - Required: three consecutive frames present them in order, `fill` goes 3→2→1→0, then the next frame gives 0/0 with one `underrun` pulse.
- **Full**
  - Stimulus: push 9 samples with DEPTH=8 and no frames.
  - Required: `in_ready`=0 after 8 samples, the 9th is not accepted, `fill`=8. After one frame, `in_ready`=1 and `fill`=7.
- **Simultaneous push and pop**
  - Stimulus: with `fill`=4, assert a push on the `frame_tick` cycle.
  - Required: `fill` stays 4 and the output is the old head.
  - Stimulus: same on an empty FIFO.
  - Required: `underrun` pulses and `fill` becomes 1.
- **Mute**
  - Stimulus: `fill`=2, `mute`=1 for one frame.
  - Required: output 0/0, `fill`=1, no underrun. Next frame with `mute`=0 presents the second sample.
- **Counter saturation**
  - Stimulus: 300 empty frames.
  - Required: `underrun_cnt`=255 and 300 `underrun` pulses.
  - Stimulus: mid-run `rst` pulse.
  - Required: count returns to 0 immediately.
